// File: rtl/fifo_sample_serializer.sv
// fifo_sample_serializer: pops signed samples from the waveform FIFO and
// shifts them MSB-first onto a 3-wire DAC link (sclk/sdata/cs_n).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for enable with a non-empty FIFO
// REQ   | pop strobe is high for this single cycle
// LATCH | capture FIFO data and the effective divider
// SHIFT | frame active, sclk toggling every eff_div cycles
// GAP   | inter-frame gap of eff_div cycles with cs_n high
module fifo_sample_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  empty_i,
    output logic                  rd_en_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  sclk_o,
    output logic                  sdata_o,
    output logic                  cs_n_o,
    output logic                  busy_o,
    output logic                  underrun_o
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LATCH = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DIV_WIDTH-1:0]  eff_div;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_WIDTH-1:0]  div_sel;

    // A zero divider would stall the down-counter, so it is promoted to 1.
    always_comb begin
        div_sel = (div_i == '0) ? DIV_WIDTH'(1) : div_i;
    end

    // Sequencer: all outputs are registered so the serial pins are glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            eff_div    <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            rd_en_o    <= 1'b0;
            sclk_o     <= 1'b0;
            sdata_o    <= 1'b0;
            cs_n_o     <= 1'b1;
            busy_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            rd_en_o    <= 1'b0;
            underrun_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i && !empty_i) begin
                        state   <= REQ;
                        rd_en_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                REQ: begin
                    state <= LATCH;
                end
                LATCH: begin
                    shift_reg <= data_i;
                    eff_div   <= div_sel;
                    div_cnt   <= div_sel - DIV_WIDTH'(1);
                    bit_cnt   <= '0;
                    cs_n_o    <= 1'b0;
                    sclk_o    <= 1'b0;
                    sdata_o   <= data_i[DATA_WIDTH-1];
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == '0) begin
                        div_cnt <= eff_div - DIV_WIDTH'(1);
                        if (!sclk_o) begin
                            sclk_o <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit so it is
                            // stable for a full half-period before the rise.
                            sclk_o    <= 1'b0;
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                            sdata_o   <= shift_reg[DATA_WIDTH-2];
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                                state   <= GAP;
                                cs_n_o  <= 1'b1;
                                sdata_o <= 1'b0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_WIDTH'(1);
                    end
                end
                GAP: begin
                    if (div_cnt == '0) begin
                        state      <= IDLE;
                        busy_o     <= 1'b0;
                        underrun_o <= en_i && empty_i;
                    end else begin
                        div_cnt <= div_cnt - DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_sample_serializer.md
# fifo_sample_serializer

Read-side consumer for the sample FIFO fed by the waveform generator. Whenever enabled and the FIFO is not empty, it pops one signed sample and shifts it out MSB-first over a 3-wire serial DAC link (sclk/sdata/cs_n) at a programmable bit rate. It then returns to fetch the next sample. It closes the generator → FIFO → DAC path and flags underruns when the FIFO runs dry during streaming.

## Interface
- DATA_WIDTH, 16 (from fifo_defines_pkg): sample width in bits; also the frame length.
- DIV_WIDTH, 8: width of the bit-clock divider input.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en_i  input  1  streaming enable.
- div_i  input  DIV_WIDTH  sclk half-period in clk cycles; 0 is treated as 1.
- empty_i  input  1  FIFO empty flag.
- rd_en_o  output  1  FIFO pop strobe, exactly one cycle per sample.
- data_i  input  DATA_WIDTH  FIFO read data, signed, valid the cycle after rd_en_o.
- sclk_o  output  1  serial bit clock; idles low.
- sdata_o  output  1  serial data, MSB first.
- cs_n_o  output  1  frame select, active low.
- busy_o  output  1  high from the pop until the end of the inter-frame gap.
- underrun_o  output  1  one-cycle pulse when the FIFO is empty at a sample boundary while streaming.

## Operation
- Reset values: rd_en_o=0, sclk_o=0, sdata_o=0, cs_n_o=1, busy_o=0, underrun_o=0; FSM=IDLE; shift register and counters cleared.
- FSM states: IDLE, REQ, LATCH, SHIFT, GAP.
- IDLE → REQ: when en_i=1 and empty_i=0. Otherwise stay in IDLE.
- REQ: rd_en_o=1 for this single cycle, then go to LATCH.
- LATCH: capture data_i into the shift register, latch eff_div = (div_i==0 ? 1 : div_i), clear the bit counter, then go to SHIFT.
- SHIFT: cs_n_o=0 and sdata_o=shift_reg[MSB].
  - sclk_o toggles every eff_div cycles, starting low.
  - On each falling edge the register shifts left by one.
  - After DATA_WIDTH full sclk periods (DATA_WIDTH falling edges), go to GAP.
- GAP: cs_n_o=1, sclk_o=0, sdata_o=0 for eff_div cycles, then go to IDLE.
- underrun_o: pulses on the GAP→IDLE transition cycle if en_i=1 and empty_i=1. It never fires on a first-start from reset with an empty FIFO.
- en_i deasserted mid-frame: the current frame completes normally, and no new pop occurs.
- empty_i is ignored outside IDLE.
- div_i changes mid-frame have no effect until the next LATCH.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The partial frame is abandoned and the popped sample is lost.
- Arithmetic: data is shifted bit-exact with no sign manipulation. Counters are sized as clog2(DATA_WIDTH+1) for bits and DIV_WIDTH for the divider.

## Timing
- Let cycle 0 be the IDLE cycle that sees en_i=1 and empty_i=0.
  - rd_en_o=1 in cycle 1.
  - Capture in cycle 2.
  - cs_n_o falls and the MSB appears in cycle 3.
- In cycle 3+k·eff_div, sclk_o takes the value (k odd) for k = 0..2·DATA_WIDTH−1.
- The DAC samples on rising edges; data is stable for eff_div cycles on each side of every rising edge.
- cs_n_o is low for exactly 2·eff_div·DATA_WIDTH cycles, followed by eff_div cycles of gap.
- Pop-to-pop period with a non-empty FIFO: 3 + 2·eff_div·DATA_WIDTH + eff_div cycles.
- busy_o is high from cycle 1 through the last GAP cycle.
- rd_en_o is never asserted while empty_i=1 in the same cycle, and never twice within one frame.

## Test plan
- Reset and idle:
  - Stimulus: rst low, then released with en_i=0 and empty_i=0.
  - Required: all outputs hold their reset values, and rd_en_o never asserts.
- Single frame:
  - Stimulus: DATA_WIDTH=16, div_i=2, one sample 0xA5C3, en_i=1.
  - Required: one rd_en_o pulse, cs_n_o low for 64 cycles, and the bits seen at the 16 sclk rising edges equal 1010_0101_1100_0011.
  - After the gap, underrun_o pulses once while the FIFO is empty.
- Back-to-back:
  - Stimulus: three samples 0x8000, 0x0001, 0x7FFF; div_i=1.
  - Required: pops spaced 36 cycles apart, all frames bit-exact, and no underrun_o until after the third frame.
- div_i=0:
  - Stimulus: sample 0xFFFF with div_i=0.
  - Required: behaviour identical to div_i=1, i.e. a 32-cycle frame with sdata_o=1 throughout.
- Mid-frame disable and divider change:
  - Stimulus: drop en_i and change div_i from 2 to 5 at bit 4.
  - Required: the frame completes at div 2 and no further rd_en_o is issued.
- Reset mid-frame:
  - Stimulus: assert rst at bit 7.
  - Required: cs_n_o=1, sclk_o=0, busy_o=0 asynchronously.
  - After release with a non-empty FIFO, a fresh pop and a full frame follow.
